// File: rtl/hv_window_monitor_if.sv
// Sample stream, live window configuration and limit flags of the HV window monitor.
// The master drives samples and thresholds; the slave (monitor) returns registered flags.
interface hv_window_monitor_if #(
  parameter int DATA_W = 12
);
  logic              sample_valid;
  logic [DATA_W-1:0] sample;
  logic [DATA_W-1:0] thr_low;
  logic [DATA_W-1:0] thr_high;
  logic [DATA_W-1:0] hyst;
  logic              vn_l;
  logic              vn_h;
  logic              stale;
  logic              cfg_err;

  modport master (
    output sample_valid, sample, thr_low, thr_high, hyst,
    input  vn_l, vn_h, stale, cfg_err
  );

  modport slave (
    input  sample_valid, sample, thr_low, thr_high, hyst,
    output vn_l, vn_h, stale, cfg_err
  );
endinterface

// File: rtl/hv_window_monitor.sv
// Debounced low/high window comparator with hysteresis and stale-sample watchdog; flags are
// registered one clk after the deciding strobe. No backpressure: every strobe is consumed.
module hv_window_monitor #(
  parameter int DATA_W   = 12,
  parameter int DEBOUNCE = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  hv_window_monitor_if.slave mon
);
  localparam int                WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]   TO_V  = WD_W'(TIMEOUT);
  localparam logic [7:0]        DB_V  = 8'(DEBOUNCE);
  localparam logic [DATA_W:0]   MAX_V = {1'b0, {DATA_W{1'b1}}};

  typedef enum logic [1:0] {ST_OK, ST_SET_PEND, ST_TRIP, ST_CLR_PEND} flag_st_e;

  typedef struct packed {
    flag_st_e   st;
    logic [7:0] cnt;
  } flag_t;

  localparam flag_t FLAG_IDLE = '{st: ST_OK, cnt: 8'd0};

  // Shared by both flags; qual/rel are already oriented for the low or high side.
  function automatic flag_t flag_next(flag_t cur, logic valid, logic qual, logic rel);
    flag_t nxt;
    nxt = cur;
    if (valid) begin
      case (cur.st)
        ST_OK: begin
          nxt.cnt = 8'd0;
          if (qual) begin
            if (DB_V == 8'd1) nxt.st = ST_TRIP;
            else begin
              nxt.st  = ST_SET_PEND;
              nxt.cnt = 8'd1;
            end
          end
        end
        ST_SET_PEND: begin
          if (!qual)                        nxt = FLAG_IDLE;
          else if (cur.cnt + 8'd1 == DB_V)  nxt = '{st: ST_TRIP, cnt: 8'd0};
          else                              nxt.cnt = cur.cnt + 8'd1;
        end
        ST_TRIP: begin
          nxt.cnt = 8'd0;
          if (rel) begin
            if (DB_V == 8'd1) nxt.st = ST_OK;
            else begin
              nxt.st  = ST_CLR_PEND;
              nxt.cnt = 8'd1;
            end
          end
        end
        ST_CLR_PEND: begin
          if (!rel)                         nxt = '{st: ST_TRIP, cnt: 8'd0};
          else if (cur.cnt + 8'd1 == DB_V)  nxt = FLAG_IDLE;
          else                              nxt.cnt = cur.cnt + 8'd1;
        end
        default: nxt = FLAG_IDLE;
      endcase
    end
    return nxt;
  endfunction

  flag_t           low_q, low_d, high_q, high_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            stale_q, stale_d;
  logic            cfg_err_q, cfg_err_d;
  logic            vn_l_q, vn_l_d;
  logic            vn_h_q, vn_h_d;

  logic [DATA_W:0] rel_low_sum, rel_low, rel_high;
  logic            low_qual, low_rel, high_qual, high_rel;

  always_comb begin
    // Release levels carry an extra bit so the sum cannot wrap before saturation.
    rel_low_sum = {1'b0, mon.thr_low} + {1'b0, mon.hyst};
    rel_low     = (rel_low_sum > MAX_V) ? MAX_V : rel_low_sum;
    rel_high    = (mon.thr_high >= mon.hyst) ? {1'b0, mon.thr_high - mon.hyst} : '0;

    low_qual  = mon.sample < mon.thr_low;
    low_rel   = {1'b0, mon.sample} >= rel_low;
    high_qual = mon.sample > mon.thr_high;
    high_rel  = {1'b0, mon.sample} <= rel_high;

    cfg_err_d = mon.thr_low >= mon.thr_high;

    low_d   = FLAG_IDLE;
    high_d  = FLAG_IDLE;
    wd_d    = '0;
    stale_d = 1'b0;
    if (enable) begin
      low_d  = flag_next(low_q,  mon.sample_valid, low_qual,  low_rel);
      high_d = flag_next(high_q, mon.sample_valid, high_qual, high_rel);
      if (!mon.sample_valid) begin
        wd_d    = (wd_q < TO_V) ? wd_q + WD_W'(1) : wd_q;
        stale_d = stale_q | (wd_d == TO_V);
      end
    end

    // Built from next-state so a flag moves on the same edge that decides it.
    vn_l_d = enable & ((low_d.st == ST_TRIP) | (low_d.st == ST_CLR_PEND) | stale_d | cfg_err_d);
    vn_h_d = enable & ((high_d.st == ST_TRIP) | (high_d.st == ST_CLR_PEND) | cfg_err_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      low_q     <= FLAG_IDLE;
      high_q    <= FLAG_IDLE;
      wd_q      <= '0;
      stale_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      vn_l_q    <= 1'b0;
      vn_h_q    <= 1'b0;
    end else begin
      low_q     <= low_d;
      high_q    <= high_d;
      wd_q      <= wd_d;
      stale_q   <= stale_d;
      cfg_err_q <= cfg_err_d;
      vn_l_q    <= vn_l_d;
      vn_h_q    <= vn_h_d;
    end
  end

  assign mon.vn_l    = vn_l_q;
  assign mon.vn_h    = vn_h_q;
  assign mon.stale   = stale_q;
  assign mon.cfg_err = cfg_err_q;
endmodule

// File: tb/tb_hv_window_monitor.sv
// Directed bench for hv_window_monitor: debounce, hysteresis, watchdog, config fault, reset/enable.
module tb_hv_window_monitor;
  localparam int DATA_W = 12;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  int   n_chk  = 0;
  int   n_pass = 0;

  hv_window_monitor_if #(.DATA_W(DATA_W)) mon ();

  hv_window_monitor #(.DATA_W(DATA_W), .DEBOUNCE(4), .TIMEOUT(64)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .mon    (mon)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One strobe; returns on the falling edge after the edge that consumed it.
  task automatic send(input logic [DATA_W-1:0] v);
    @(negedge clk);
    mon.sample       = v;
    mon.sample_valid = 1'b1;
    @(negedge clk);
    mon.sample_valid = 1'b0;
  endtask

  task automatic send_n(input logic [DATA_W-1:0] v, input int n);
    for (int i = 0; i < n; i++) send(v);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_thr(input logic [DATA_W-1:0] lo, input logic [DATA_W-1:0] hi);
    mon.thr_low  = lo;
    mon.thr_high = hi;
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    mon.sample_valid = 1'b0;
    mon.sample = '0;
    set_thr(12'd1000, 12'd3000);
    mon.hyst = 12'd50;
    idle(3);
    check("rst_vn_l", mon.vn_l, 0);
    check("rst_vn_h", mon.vn_h, 0);
    check("rst_stale", mon.stale, 0);
    check("rst_cfg_err", mon.cfg_err, 0);
    reset = 1'b0;

    // Under-voltage debounce
    send_n(12'd900, 3); send(12'd1010);
    check("uv_broken_run", mon.vn_l, 0);
    send_n(12'd900, 3);
    check("uv_3rd", mon.vn_l, 0);
    send(12'd900);
    check("uv_4th", mon.vn_l, 1);
    check("uv_vn_h", mon.vn_h, 0);

    // Hysteresis release (rel_low = 1050)
    send_n(12'd1020, 10);
    check("uv_in_band", mon.vn_l, 1);
    send_n(12'd1050, 3); send(12'd1040);
    check("uv_broken_rel", mon.vn_l, 1);
    send_n(12'd1050, 3);
    check("uv_rel_3rd", mon.vn_l, 1);
    send(12'd1050);
    check("uv_rel_4th", mon.vn_l, 0);

    // Over-voltage trip and release (rel_high = 2950)
    send_n(12'd3100, 3);
    check("ov_3rd", mon.vn_h, 0);
    send(12'd3100);
    check("ov_4th", mon.vn_h, 1);
    check("ov_vn_l", mon.vn_l, 0);
    send_n(12'd2950, 3);
    check("ov_rel_3rd", mon.vn_h, 1);
    send(12'd2950);
    check("ov_rel_4th", mon.vn_h, 0);

    // Floored release level: hyst larger than thr_high
    send_n(12'd3100, 4);
    check("ov_retrip", mon.vn_h, 1);
    mon.hyst = 12'd4000;
    send_n(12'd2000, 4);
    check("floor_2000", mon.vn_h, 1);
    send_n(12'd0, 3);
    check("floor_0_3rd", mon.vn_h, 1);
    send(12'd0);
    check("floor_0_4th", mon.vn_h, 0);
    check("zero_trips_low", mon.vn_l, 1);
    mon.hyst = 12'd50;
    send_n(12'd1050, 4);
    check("zero_low_rel", mon.vn_l, 0);

    // Watchdog
    send_n(12'd3100, 4);
    check("wd_pre_vn_h", mon.vn_h, 1);
    idle(63);
    check("wd_63", mon.stale, 0);
    idle(1);
    check("wd_64_stale", mon.stale, 1);
    check("wd_64_vn_l", mon.vn_l, 1);
    check("wd_64_vn_h", mon.vn_h, 1);
    idle(5);
    check("wd_sat", mon.stale, 1);
    send(12'd2000);
    check("wd_clr_stale", mon.stale, 0);
    check("wd_clr_vn_l", mon.vn_l, 0);
    check("wd_clr_vn_h", mon.vn_h, 1);
    send_n(12'd2000, 3);
    check("wd_ov_rel", mon.vn_h, 0);
    idle(62);
    send(12'd2000);
    check("wd_sample_wins", mon.stale, 0);

    // Config fault
    @(negedge clk);
    set_thr(12'd3000, 12'd1000);
    idle(1);
    check("cfg_err", mon.cfg_err, 1);
    check("cfg_vn_l", mon.vn_l, 1);
    check("cfg_vn_h", mon.vn_h, 1);
    set_thr(12'd2000, 12'd2000);
    idle(1);
    check("cfg_equal", mon.cfg_err, 1);
    set_thr(12'd1000, 12'd3000);
    idle(1);
    check("cfg_restore", mon.cfg_err, 0);
    check("cfg_rest_vn_l", mon.vn_l, 0);
    check("cfg_rest_vn_h", mon.vn_h, 0);

    // Reset mid-debounce
    send_n(12'd900, 2);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    send_n(12'd900, 2);
    check("rst_pend_discard", mon.vn_l, 0);
    send_n(12'd900, 2);
    check("rst_fresh_trip", mon.vn_l, 1);
    send_n(12'd1050, 4);
    check("rst_fresh_rel", mon.vn_l, 0);

    // Enable
    send_n(12'd3100, 4);
    check("en_pre_vn_h", mon.vn_h, 1);
    @(negedge clk); enable = 1'b0;
    idle(1);
    check("en_off_vn_h", mon.vn_h, 0);
    idle(80);
    check("en_off_stale", mon.stale, 0);
    check("en_off_vn_l", mon.vn_l, 0);
    set_thr(12'd3000, 12'd1000);
    idle(1);
    check("en_off_cfg_err", mon.cfg_err, 1);
    check("en_off_cfg_vn_l", mon.vn_l, 0);
    set_thr(12'd1000, 12'd3000);
    send_n(12'd3100, 3);
    check("en_off_ignored", mon.vn_h, 0);
    enable = 1'b1;
    idle(63);
    check("en_wd_63", mon.stale, 0);
    idle(1);
    check("en_wd_64", mon.stale, 1);
    send_n(12'd3100, 3);
    check("en_clean_3rd", mon.vn_h, 0);
    send(12'd3100);
    check("en_clean_4th", mon.vn_h, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
